// File: rtl/spi_ctrl_pkg.sv
// Shared types and sizing helpers for the SPI transaction sequencer.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_TX,
    ST_START,
    ST_RUN,
    ST_HOLD,
    ST_GAP
  } spi_xfer_state_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of the shared CS timing counter; never narrower than one bit.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: owns chip-select timing and feeds the byte engine
// one TX byte at a time, returning each RX byte and a completion pulse.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int  MAX_LEN  = 16,
  parameter int  CS_SETUP = 2,
  parameter int  CS_HOLD  = 2,
  parameter int  CS_IDLE  = 1,
  localparam int LEN_W    = len_w(MAX_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             abort_i,
  input  logic             tx_valid_i,
  input  logic [7:0]       tx_data_i,
  output logic             tx_ready_o,
  output logic             rx_valid_o,
  output logic [7:0]       rx_data_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             cs_no,
  output logic             eng_start_o,
  output logic [7:0]       eng_tx_byte_o,
  input  logic [7:0]       eng_rx_byte_i,
  input  logic             eng_busy_i
);

  localparam int CNT_W = cnt_w(CS_SETUP, CS_HOLD, CS_IDLE);

  // HOLD's first cycle is the one carrying the last rx_valid_o, so it runs to
  // CS_HOLD inclusive; SETUP and GAP last max(param,1) cycles.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'((CS_IDLE > 0) ? CS_IDLE - 1 : 0);

  spi_xfer_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             abort_q, abort_d;
  logic             seen_busy_q, seen_busy_d;
  logic             req_ready_q, req_ready_d;
  logic             tx_ready_q, tx_ready_d;
  logic             cs_n_q, cs_n_d;
  logic             eng_start_q, eng_start_d;
  logic [7:0]       eng_tx_byte_q, eng_tx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && req_valid_i && req_ready_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = '0;
    rem_d         = rem_q;
    abort_d       = abort_q;
    seen_busy_d   = seen_busy_q;
    eng_tx_byte_d = eng_tx_byte_q;
    rx_valid_d    = 1'b0;
    rx_data_d     = rx_data_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d = req_len_i;
          if (req_len_i == '0) done_d = 1'b1;
          else                 state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = ST_WAIT_TX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_TX: begin
        // Abort takes priority over a coincident TX handshake.
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = ST_HOLD;
        end else if (tx_valid_i && tx_ready_q) begin
          eng_tx_byte_d = tx_data_i;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        seen_busy_d = 1'b0;
        if (abort_i) abort_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_i) abort_d = 1'b1;
        if (eng_busy_i) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = eng_rx_byte_i;
          rem_d      = rem_q - 1'b1;
          if (rem_q == LEN_W'(1) || abort_q || abort_i) state_d = ST_HOLD;
          else                                          state_d = ST_WAIT_TX;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          done_d    = 1'b1;
          aborted_d = abort_q;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          abort_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d = (state_d == ST_IDLE) && !accept;
    cs_n_d      = (state_d == ST_IDLE) || (state_d == ST_GAP);
    tx_ready_d  = (state_d == ST_WAIT_TX) && !eng_busy_i;
    eng_start_d = (state_d == ST_START);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset branch is synchronous.
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      abort_q       <= 1'b0;
      seen_busy_q   <= 1'b0;
      req_ready_q   <= 1'b0;
      tx_ready_q    <= 1'b0;
      cs_n_q        <= 1'b1;
      eng_start_q   <= 1'b0;
      eng_tx_byte_q <= '0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      abort_q       <= abort_d;
      seen_busy_q   <= seen_busy_d;
      req_ready_q   <= req_ready_d;
      tx_ready_q    <= tx_ready_d;
      cs_n_q        <= cs_n_d;
      eng_start_q   <= eng_start_d;
      eng_tx_byte_q <= eng_tx_byte_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign tx_ready_o    = tx_ready_q;
  assign cs_no         = cs_n_q;
  assign eng_start_o   = eng_start_q;
  assign eng_tx_byte_o = eng_tx_byte_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a loopback byte-engine model.
module tb_spi_xfer_ctrl;
  import spi_ctrl_pkg::*;

  localparam int MAX_LEN  = 16;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 1;
  localparam int LEN_W    = len_w(MAX_LEN);

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [LEN_W-1:0] req_len_i = '0;
  logic             abort_i = 1'b0;
  logic             tx_valid_i = 1'b0;
  logic [7:0]       tx_data_i = '0;
  logic             tx_ready_o;
  logic             rx_valid_o;
  logic [7:0]       rx_data_o;
  logic             done_o;
  logic             aborted_o;
  logic             cs_no;
  logic             eng_start_o;
  logic [7:0]       eng_tx_byte_o;
  logic [7:0]       eng_rx_byte_i = '0;
  logic             eng_busy_i = 1'b0;

  spi_xfer_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_len_i    (req_len_i),
    .abort_i      (abort_i),
    .tx_valid_i   (tx_valid_i),
    .tx_data_i    (tx_data_i),
    .tx_ready_o   (tx_ready_o),
    .rx_valid_o   (rx_valid_o),
    .rx_data_o    (rx_data_o),
    .done_o       (done_o),
    .aborted_o    (aborted_o),
    .cs_no        (cs_no),
    .eng_start_o  (eng_start_o),
    .eng_tx_byte_o(eng_tx_byte_o),
    .eng_rx_byte_i(eng_rx_byte_i),
    .eng_busy_i   (eng_busy_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Event counters sampled at the active edge.
  int cyc = 0;
  int start_cnt = 0;
  int hs_cnt = 0;
  int acc_cnt = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (eng_start_o === 1'b1) start_cnt <= start_cnt + 1;
    if (tx_valid_i && tx_ready_o === 1'b1) hs_cnt <= hs_cnt + 1;
    if (req_valid_i && req_ready_o === 1'b1) acc_cnt <= acc_cnt + 1;
  end

  // Loopback engine: busy for four cycles, returns the byte it was given.
  int         eng_cnt = 0;
  logic [7:0] eng_shift = '0;
  always @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eng_cnt       <= 0;
      eng_busy_i    <= 1'b0;
      eng_rx_byte_i <= '0;
    end else if (eng_cnt != 0) begin
      if (eng_cnt == 1) begin
        eng_busy_i    <= 1'b0;
        eng_rx_byte_i <= eng_shift;
      end
      eng_cnt <= eng_cnt - 1;
    end else if (eng_start_o === 1'b1) begin
      eng_busy_i <= 1'b1;
      eng_shift  <= eng_tx_byte_o;
      eng_cnt    <= 4;
    end
  end

  // Scoreboard monitor.
  logic [7:0] rx_q[$];
  bit         done_q[$];
  int         rx_cnt = 0;
  int         done_cnt = 0;
  int         last_rx_cyc = 0;
  int         done_cyc = 0;
  bit         ready_busy = 1'b0;
  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1) begin
      rx_cnt      <= rx_cnt + 1;
      last_rx_cyc <= cyc;
      if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
      else                  check("rx_data", rx_data_o, rx_q.pop_front());
    end
    if (done_o === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (done_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        check("aborted", aborted_o, done_q.pop_front());
        check("cs_at_done", cs_no, 1);
      end
    end
    if (req_ready_o === 1'b1 && cs_no === 1'b0) ready_busy <= 1'b1;
  end

  task automatic send_req(input int len, output int t1);
    int n;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("req_ready_wait", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_len_i   = LEN_W'(len);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    t1 = cyc;
  endtask

  task automatic feed(input logic [7:0] b, input bit push);
    int n;
    n = 0;
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    while (tx_ready_o !== 1'b1 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("tx_ready_wait", tx_ready_o, 1);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    if (push) rx_q.push_back(b);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("done_wait", done_cnt >= target, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    int t1, d0, s0, h0, r0, a0, gap, n;
    bit cs_ok;

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_cs", cs_no, 1);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_start", eng_start_o, 0);
    check("rst_tx_ready", tx_ready_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_aborted", aborted_o, 0);
    check("rst_eng_tx", eng_tx_byte_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", req_ready_o, 1);

    // Three-byte loopback transfer
    d0 = done_cnt; s0 = start_cnt;
    done_q.push_back(1'b0);
    send_req(3, t1);
    check("t1_cs_fall", cs_no, 0);
    feed(8'hA5, 1'b1);
    check("t1_first_start", eng_start_o, 1);
    check("t1_start_latency", cyc - t1, CS_SETUP + 1);
    feed(8'h3C, 1'b1);
    feed(8'hFF, 1'b1);
    wait_done(d0 + 1);
    check("t1_starts", start_cnt - s0, 3);
    check("t1_rx_to_done", done_cyc - last_rx_cyc, CS_HOLD + 1);

    // Zero-length request
    d0 = done_cnt; s0 = start_cnt;
    done_q.push_back(1'b0);
    send_req(0, t1);
    check("t2_done", done_o, 1);
    check("t2_cs", cs_no, 1);
    check("t2_ready_low", req_ready_o, 0);
    @(negedge clk_i);
    check("t2_ready_back", req_ready_o, 1);
    check("t2_cs_still_high", cs_no, 1);
    wait_done(d0 + 1);
    check("t2_no_start", start_cnt - s0, 0);

    // TX stall holds chip-select
    d0 = done_cnt; r0 = rx_cnt;
    done_q.push_back(1'b0);
    send_req(2, t1);
    feed(8'h11, 1'b1);
    cs_ok = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (cs_no !== 1'b0) cs_ok = 1'b0;
    end
    check("t3_cs_held", cs_ok, 1);
    check("t3_tx_ready_waiting", tx_ready_o, 1);
    feed(8'h22, 1'b1);
    wait_done(d0 + 1);
    check("t3_rx_count", rx_cnt - r0, 2);

    // Abort during byte 2
    d0 = done_cnt; s0 = start_cnt; h0 = hs_cnt;
    done_q.push_back(1'b1);
    send_req(4, t1);
    feed(8'h31, 1'b1);
    feed(8'h42, 1'b1);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i    = 1'b0;
    tx_valid_i = 1'b1;
    tx_data_i  = 8'h53;
    wait_done(d0 + 1);
    tx_valid_i = 1'b0;
    check("t4_starts", start_cnt - s0, 2);
    check("t4_handshakes", hs_cnt - h0, 2);
    check("t4_rx_to_done", done_cyc - last_rx_cyc, CS_HOLD + 1);
    check("t4_cs_high", cs_no, 1);

    // Reset mid-RUN
    d0 = done_cnt; r0 = rx_cnt;
    send_req(2, t1);
    feed(8'h77, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("t5_cs", cs_no, 1);
    check("t5_ready_low", req_ready_o, 0);
    check("t5_start", eng_start_o, 0);
    check("t5_tx_ready", tx_ready_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("t5_ready_back", req_ready_o, 1);
    repeat (10) @(negedge clk_i);
    check("t5_no_rx", rx_cnt - r0, 0);
    check("t5_no_done", done_cnt - d0, 0);
    done_q.push_back(1'b0);
    send_req(1, t1);
    feed(8'h9C, 1'b1);
    wait_done(d0 + 1);

    // Back-to-back requests with req_valid_i held high
    d0 = done_cnt; s0 = start_cnt; a0 = acc_cnt;
    gap = 0;
    done_q.push_back(1'b0);
    done_q.push_back(1'b0);
    fork
      begin
        n = 0;
        req_valid_i = 1'b1;
        req_len_i   = LEN_W'(1);
        while (acc_cnt < a0 + 2 && n < 300) begin
          @(negedge clk_i);
          n++;
        end
        req_valid_i = 1'b0;
      end
      begin
        feed(8'hE1, 1'b1);
        feed(8'hE2, 1'b1);
      end
      begin
        int k;
        k = 0;
        while (done_o !== 1'b1 && k < 300) begin
          @(negedge clk_i);
          k++;
        end
        while (cs_no === 1'b1 && gap < 50) begin
          gap++;
          @(negedge clk_i);
        end
      end
    join
    wait_done(d0 + 2);
    check("t6_accepts", acc_cnt - a0, 2);
    check("t6_starts", start_cnt - s0, 2);
    check("t6_cs_gap", gap >= 2, 1);

    check("ready_while_cs_low", ready_busy, 0);
    check("rx_queue_empty", rx_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Transaction sequencer for the byte-level SPI host engine.
- Accepts a command for an N-byte transfer and owns chip-select, including setup, hold and idle-gap timing.
- Feeds TX bytes to the engine one at a time, then returns each RX byte and signals completion.
- Sits between the bus-side SPI register block and the engine instance at the top level.

Parameters:
- MAX_LEN, 16: maximum bytes per transaction. Length width LEN_W = $clog2(MAX_LEN+1).
- CS_SETUP, 2: clk cycles between cs_no falling and the first eng_start_o.
- CS_HOLD, 2: clk cycles between the last byte completing and cs_no rising.
- CS_IDLE, 1: clk cycles cs_no stays high before req_ready_o reasserts.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  transaction request.
- req_ready_o  out  1  controller idle; the request is accepted on valid&ready.
- req_len_i  in  LEN_W  byte count, 0..MAX_LEN.
- abort_i  in  1  end the transaction early. Level-sampled; ignored in IDLE.
- tx_valid_i  in  1  TX byte available.
- tx_data_i  in  8  TX byte.
- tx_ready_o  out  1  TX byte consumed on valid&ready.
- rx_valid_o  out  1  one-cycle pulse, RX byte valid. No backpressure.
- rx_data_o  out  8  RX byte.
- done_o  out  1  one-cycle pulse, transaction finished.
- aborted_o  out  1  qualifies done_o; high if the transaction ended by abort.
- cs_no  out  1  chip select, active-low.
- eng_start_o  out  1  one-cycle start pulse to the engine.
- eng_tx_byte_o  out  8  byte presented to the engine. Held stable until the engine goes busy.
- eng_rx_byte_i  in  8  engine RX byte.
- eng_busy_i  in  1  engine busy.

Behaviour:
- All outputs are registered.
- Reset values: req_ready_o=0 during reset (1 from the first cycle after reset). cs_no=1. eng_start_o=0. tx_ready_o=0. rx_valid_o=0. done_o=0. aborted_o=0. eng_tx_byte_o=0. rx_data_o=0. State is IDLE, counters 0.
- States: IDLE, SETUP, WAIT_TX, START, RUN, HOLD, GAP.
- IDLE:
  - req_ready_o=1.
  - Accept at cycle T: latch the length into rem_q.
  - len!=0: cs_no=0 from T+1, go to SETUP.
  - len==0: done_o=1 at T+1, cs_no never asserts, stay in IDLE (req_ready_o=0 at T+1 only).
- SETUP: count CS_SETUP cycles, then go to WAIT_TX. abort_i here goes to HOLD.
- WAIT_TX:
  - tx_ready_o=1 while eng_busy_i=0.
  - On a handshake: latch tx_data_i into eng_tx_byte_o, go to START.
  - A TX stall holds here indefinitely with cs_no low.
  - abort_i goes to HOLD with no byte consumed.
- START: eng_start_o=1 for exactly one cycle, go to RUN. Clear seen_busy.
- RUN:
  - Set seen_busy when eng_busy_i=1.
  - Exit on eng_busy_i=0 with seen_busy=1. On exit:
    - rx_valid_o=1 and rx_data_o=eng_rx_byte_i on the next cycle.
    - rem_q decrements.
    - rem_q==0 or abort seen: go to HOLD. Otherwise go to WAIT_TX.
  - abort_i during RUN is latched; the current byte always completes.
- HOLD: count CS_HOLD cycles, then cs_no=1, done_o=1, aborted_o=abort latch. Go to GAP.
- GAP: count CS_IDLE cycles, then go to IDLE. Clear the abort latch.
- Minimum timing:
  - cs_no falls at T+1.
  - First eng_start_o at T+1+CS_SETUP+1 at the earliest.
  - Last rx_valid_o to done_o: CS_HOLD+1 cycles.
- req_valid_i outside IDLE is ignored (not accepted).
- Reset asserted mid-transaction: on the next clk edge all state goes to reset values and cs_no=1. No done_o or rx_valid_o is emitted. The engine is reset by the same rst_ni.
- Simultaneous tx_valid_i and abort_i in WAIT_TX: abort wins, the byte is not consumed.
- Counters are sized $clog2(max(CS_*)+1). A parameter value of 0 means the state lasts 1 cycle (no zero-length states).

Decomposition:
- spi_ctrl_pkg holds the state typedef enum (spi_xfer_state_e) and a LEN_W helper function.
- No sub-module; the delay counter is inline. Instantiated alongside the engine in the top level.

Test Plan:
- CS_SETUP=2, CS_HOLD=2, len=3, TX 0xA5,0x3C,0xFF with miso looped to mosi:
  - cs_no falls at T+1.
  - Three eng_start_o pulses.
  - rx_data_o = 0xA5, 0x3C, 0xFF.
  - done_o=1 with aborted_o=0, cs_no rises with it.
- len=0 -> done_o at T+1; cs_no stays 1; no eng_start_o.
- len=2, TX withheld 20 cycles after the first byte -> cs_no held 0 throughout. The second byte completes, then a normal done_o.
- len=4, abort_i pulsed during byte 2 RUN:
  - Byte 2 completes with rx_valid_o.
  - No third eng_start_o.
  - done_o with aborted_o=1, cs_no=1 after CS_HOLD.
- rst_ni low for 1 cycle mid-RUN -> next cycle cs_no=1, req_ready_o=0, then 1. A new len=1 request completes normally.
- Back-to-back requests, CS_IDLE=1 -> cs_no high for at least 2 cycles between transactions. req_valid_i held high is accepted only in IDLE.
